// File: rtl/rvfi_reorder_buf.sv
// Retirement reorder buffer: multi-channel RVFI retirements in, one in-order retirement per cycle out.
// Optional same-cycle bypass of the head instruction when RVFI_REORDER_BYPASS_EN is defined.
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 1
`endif
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif
module rvfi_reorder_buf #(
   parameter int unsigned NRET  = `RISCV_FORMAL_NRET,
   parameter int unsigned XLEN  = `RISCV_FORMAL_XLEN,
   parameter int unsigned DEPTH = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NRET-1:0]      rvfi_valid,
   input  logic [64*NRET-1:0]   rvfi_order,
   input  logic [XLEN*NRET-1:0] rvfi_pc_rdata,
   input  logic [XLEN*NRET-1:0] rvfi_pc_wdata,
   output logic                 out_valid,
   output logic [63:0]          out_order,
   output logic [XLEN-1:0]      out_pc_rdata,
   output logic [XLEN-1:0]      out_pc_wdata,
   output logic                 err_window,
   output logic                 err_dup
);

   localparam int unsigned IW = $clog2(DEPTH);

   logic [63:0]      next_order_q, next_order_d;
   logic [DEPTH-1:0] slot_vld_q, slot_vld_d;
   logic [63:0]      slot_ord_q [DEPTH];
   logic [63:0]      slot_ord_d [DEPTH];
   logic [XLEN-1:0]  slot_pcr_q [DEPTH];
   logic [XLEN-1:0]  slot_pcr_d [DEPTH];
   logic [XLEN-1:0]  slot_pcw_q [DEPTH];
   logic [XLEN-1:0]  slot_pcw_d [DEPTH];

   logic             out_valid_q, out_valid_d;
   logic [63:0]      out_order_q, out_order_d;
   logic [XLEN-1:0]  out_pcr_q, out_pcr_d;
   logic [XLEN-1:0]  out_pcw_q, out_pcw_d;
   logic             err_win_q, err_win_d;
   logic             err_dup_q, err_dup_d;

   logic [IW-1:0]    head_idx, ch_idx;
   logic             head_vld, byp_hit;
   logic [NRET-1:0]  byp_sel;
   logic [DEPTH-1:0] claimed;
   logic [63:0]      ch_ord, ch_dist;

   // Accept incoming retirements into slots, then emit the head slot (or bypass channel)
   always_comb begin
      head_idx     = next_order_q[IW-1:0];
      head_vld     = slot_vld_q[head_idx];
      byp_hit      = 1'b0;
      byp_sel      = '0;
      ch_idx       = '0;
      ch_ord       = '0;
      ch_dist      = '0;
      slot_vld_d   = slot_vld_q;
      slot_ord_d   = slot_ord_q;
      slot_pcr_d   = slot_pcr_q;
      slot_pcw_d   = slot_pcw_q;
      err_win_d    = err_win_q;
      err_dup_d    = err_dup_q;
      out_valid_d  = 1'b0;
      out_order_d  = out_order_q;
      out_pcr_d    = out_pcr_q;
      out_pcw_d    = out_pcw_q;
      next_order_d = next_order_q;

`ifdef RVFI_REORDER_BYPASS_EN
      for (int c = 0; c < NRET; c++) begin
         if (!head_vld && !byp_hit && rvfi_valid[c] &&
             rvfi_order[64*c +: 64] == next_order_q) begin
            byp_hit    = 1'b1;
            byp_sel[c] = 1'b1;
         end
      end
`endif

      // A bypassed head claims its slot so a second copy this cycle is a duplicate
      claimed = slot_vld_q;
      if (byp_hit) claimed[head_idx] = 1'b1;

      for (int c = 0; c < NRET; c++) begin
         ch_ord  = rvfi_order[64*c +: 64];
         ch_dist = ch_ord - next_order_q;
         ch_idx  = ch_ord[IW-1:0];
         if (rvfi_valid[c] && !byp_sel[c]) begin
            if (ch_dist >= 64'(DEPTH)) begin
               err_win_d = 1'b1;
            end else if (claimed[ch_idx]) begin
               err_dup_d = 1'b1;
            end else begin
               claimed[ch_idx]    = 1'b1;
               slot_vld_d[ch_idx] = 1'b1;
               slot_ord_d[ch_idx] = ch_ord;
               slot_pcr_d[ch_idx] = rvfi_pc_rdata[XLEN*c +: XLEN];
               slot_pcw_d[ch_idx] = rvfi_pc_wdata[XLEN*c +: XLEN];
            end
         end
      end

      if (head_vld) begin
         out_valid_d          = 1'b1;
         out_order_d          = slot_ord_q[head_idx];
         out_pcr_d            = slot_pcr_q[head_idx];
         out_pcw_d            = slot_pcw_q[head_idx];
         slot_vld_d[head_idx] = 1'b0;
         next_order_d         = next_order_q + 64'd1;
      end else if (byp_hit) begin
         out_valid_d  = 1'b1;
         next_order_d = next_order_q + 64'd1;
         for (int c = 0; c < NRET; c++) begin
            if (byp_sel[c]) begin
               out_order_d = rvfi_order[64*c +: 64];
               out_pcr_d   = rvfi_pc_rdata[XLEN*c +: XLEN];
               out_pcw_d   = rvfi_pc_wdata[XLEN*c +: XLEN];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         next_order_q <= '0;
         slot_vld_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_ord_q[i] <= '0;
            slot_pcr_q[i] <= '0;
            slot_pcw_q[i] <= '0;
         end
         out_valid_q  <= 1'b0;
         out_order_q  <= '0;
         out_pcr_q    <= '0;
         out_pcw_q    <= '0;
         err_win_q    <= 1'b0;
         err_dup_q    <= 1'b0;
      end else begin
         next_order_q <= next_order_d;
         slot_vld_q   <= slot_vld_d;
         slot_ord_q   <= slot_ord_d;
         slot_pcr_q   <= slot_pcr_d;
         slot_pcw_q   <= slot_pcw_d;
         out_valid_q  <= out_valid_d;
         out_order_q  <= out_order_d;
         out_pcr_q    <= out_pcr_d;
         out_pcw_q    <= out_pcw_d;
         err_win_q    <= err_win_d;
         err_dup_q    <= err_dup_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_order    = out_order_q;
   assign out_pc_rdata = out_pcr_q;
   assign out_pc_wdata = out_pcw_q;
   assign err_window   = err_win_q;
   assign err_dup      = err_dup_q;

endmodule

// File: tb/tb_rvfi_reorder_buf.sv
// Scoreboard bench for rvfi_reorder_buf: a map-based reference model predicts emissions and
// sticky error flags; a negedge monitor compares DUT outputs against the expected queue.
module tb_rvfi_reorder_buf;

   localparam int unsigned NRET  = 2;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 8;
`ifdef RVFI_REORDER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic [63:0]     ord;
      logic [XLEN-1:0] pr;
      logic [XLEN-1:0] pw;
   } ent_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NRET-1:0]      rvfi_valid;
   logic [64*NRET-1:0]   rvfi_order;
   logic [XLEN*NRET-1:0] rvfi_pc_rdata;
   logic [XLEN*NRET-1:0] rvfi_pc_wdata;
   logic                 out_valid;
   logic [63:0]          out_order;
   logic [XLEN-1:0]      out_pc_rdata;
   logic [XLEN-1:0]      out_pc_wdata;
   logic                 err_window;
   logic                 err_dup;

   rvfi_reorder_buf #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clock(clk), .reset(reset),
      .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
      .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
      .out_valid(out_valid), .out_order(out_order),
      .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
      .err_window(err_window), .err_dup(err_dup)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;

   // reference model state
   ent_t        pending [logic [63:0]];
   ent_t        exp_q [$];
   ent_t        held;
   logic [63:0] nx;
   bit          exp_v, exp_ew, exp_ed, started;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: evaluate one clock edge from the spec's rules on an order-keyed map
   always @(posedge clk) begin
      bit          head, byp;
      int          byp_ch;
      bit          claimed [logic [63:0]];
      ent_t        e, be;
      logic [63:0] o;
      if (reset) begin
         pending.delete();
         exp_q.delete();
         nx = 64'd0; exp_ew = 1'b0; exp_ed = 1'b0; exp_v = 1'b0;
         held = '{ord: 64'd0, pr: '0, pw: '0};
         started = 1'b1;
      end else begin
         head = pending.exists(nx);
         byp = 1'b0; byp_ch = -1; exp_v = 1'b0;
         claimed.delete();
         if (BYP && !head) begin
            for (int c = 0; c < NRET; c++) begin
               if (!byp && rvfi_valid[c] && rvfi_order[64*c +: 64] == nx) begin
                  byp = 1'b1; byp_ch = c; claimed[nx] = 1'b1;
                  be = '{ord: nx, pr: rvfi_pc_rdata[XLEN*c +: XLEN], pw: rvfi_pc_wdata[XLEN*c +: XLEN]};
               end
            end
         end
         for (int c = 0; c < NRET; c++) begin
            o = rvfi_order[64*c +: 64];
            if (rvfi_valid[c] && c != byp_ch) begin
               if (o - nx >= 64'(DEPTH)) exp_ew = 1'b1;
               else if (pending.exists(o) || claimed.exists(o)) exp_ed = 1'b1;
               else begin
                  claimed[o] = 1'b1;
                  pending[o] = '{ord: o, pr: rvfi_pc_rdata[XLEN*c +: XLEN], pw: rvfi_pc_wdata[XLEN*c +: XLEN]};
               end
            end
         end
         if (head) begin
            e = pending[nx];
            pending.delete(nx);
            exp_q.push_back(e); held = e; exp_v = 1'b1; nx = nx + 64'd1;
         end else if (byp) begin
            exp_q.push_back(be); held = be; exp_v = 1'b1; nx = nx + 64'd1;
         end
      end
   end

   // Monitor: pop the scoreboard whenever the DUT presents a retirement
   always @(negedge clk) begin
      ent_t e;
      if (started) begin
         chk("out_valid", 64'(out_valid), 64'(exp_v));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_emit", out_order, 64'hDEAD);
            end else begin
               e = exp_q.pop_front();
               chk("out_order", out_order, e.ord);
               chk("out_pc_rdata", 64'(out_pc_rdata), 64'(e.pr));
               chk("out_pc_wdata", 64'(out_pc_wdata), 64'(e.pw));
            end
         end else begin
            chk("hold_order", out_order, held.ord);
            chk("hold_pc_rdata", 64'(out_pc_rdata), 64'(held.pr));
            chk("hold_pc_wdata", 64'(out_pc_wdata), 64'(held.pw));
         end
         chk("err_window", 64'(err_window), 64'(exp_ew));
         chk("err_dup", 64'(err_dup), 64'(exp_ed));
      end
   end

   // Apply one cycle of inputs (called at a negedge), hold them across the next posedge
   task automatic drive(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                        input logic [XLEN-1:0] r0, input logic [XLEN-1:0] w0,
                        input logic [XLEN-1:0] r1, input logic [XLEN-1:0] w1);
      rvfi_valid    = v;
      rvfi_order    = {o1, o0};
      rvfi_pc_rdata = {r1, r0};
      rvfi_pc_wdata = {w1, w0};
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(2'b00, 64'd0, 64'd0, '0, '0, '0, '0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rvfi_valid = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [63:0] o [2];
      logic [1:0]  v;
      rvfi_valid = '0; rvfi_order = '0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
      started = 1'b0; exp_v = 1'b0; nx = '0;

      // in order, two per cycle
      do_reset();
      drive(2'b11, 64'd0, 64'd1, 32'h100, 32'h104, 32'h104, 32'h108);
      drive(2'b11, 64'd2, 64'd3, 32'h108, 32'h10C, 32'h10C, 32'h110);
      idle(6);

      // reversed arrival
      do_reset();
      drive(2'b01, 64'd1, 64'd0, 32'h204, 32'h208, '0, '0);
      drive(2'b01, 64'd0, 64'd0, 32'h200, 32'h204, '0, '0);
      idle(4);

      // out-of-window then full window in order
      do_reset();
      drive(2'b01, 64'd8, 64'd0, 32'hBAD, 32'hBAD, '0, '0);
      for (int i = 0; i < 8; i += 2)
         drive(2'b11, 64'(i), 64'(i + 1), 32'(16'h300 + 4*i), 32'(16'h304 + 4*i),
               32'(16'h304 + 4*i), 32'(16'h308 + 4*i));
      idle(10);

      // duplicate order on both channels
      do_reset();
      drive(2'b11, 64'd3, 64'd3, 32'hAAA0, 32'hAAA4, 32'hBBB0, 32'hBBB4);
      drive(2'b11, 64'd0, 64'd1, 32'h400, 32'h404, 32'h404, 32'h408);
      drive(2'b11, 64'd2, 64'd4, 32'h408, 32'h40C, 32'h410, 32'h414);
      idle(7);

      // reset with entries buffered
      do_reset();
      drive(2'b11, 64'd1, 64'd2, 32'h504, 32'h508, 32'h508, 32'h50C);
      idle(1);
      do_reset();
      drive(2'b01, 64'd0, 64'd0, 32'h600, 32'h604, '0, '0);
      idle(5);

      // wrap-around of next_order
      do_reset();
      force dut.next_order_q = 64'hFFFF_FFFF_FFFF_FFFF;
      nx = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 release dut.next_order_q;
      drive(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 32'h700, 32'h704, 32'h704, 32'h708);
      idle(4);

      // randomized traffic around the window
      do_reset();
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < 2; c++) begin
            v[c] = ($urandom_range(0, 3) != 0);
            o[c] = ($urandom_range(0, 15) == 0) ? nx - 64'd1 : nx + 64'($urandom_range(0, DEPTH + 1));
         end
         drive(v, o[0], o[1], $urandom, $urandom, $urandom, $urandom);
      end
      idle(12);

      chk("drain", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
